// File: rtl/maindec_pipe_pkg.sv
// maindec_pipe_pkg
// Shared decode definitions for the registered main decoder:
//   - MIPS opcode / funct / REGIMM rt / COP0 rs field constants
//   - bit positions of each field inside the CTRL_W-bit control vector
//   - small helpers that classify HI/LO-touching SPECIAL instructions
package maindec_pipe_pkg;

  localparam int CTRL_W = 21;

  // Primary opcodes
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_REGIMM  = 6'b000001;
  localparam logic [5:0] EXE_J       = 6'b000010;
  localparam logic [5:0] EXE_JAL     = 6'b000011;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_BNE     = 6'b000101;
  localparam logic [5:0] EXE_BLEZ    = 6'b000110;
  localparam logic [5:0] EXE_BGTZ    = 6'b000111;
  localparam logic [5:0] EXE_ADDI    = 6'b001000;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_SLTI    = 6'b001010;
  localparam logic [5:0] EXE_SLTIU   = 6'b001011;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_COP0    = 6'b010000;
  localparam logic [5:0] EXE_LB      = 6'b100000;
  localparam logic [5:0] EXE_LH      = 6'b100001;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_LBU     = 6'b100100;
  localparam logic [5:0] EXE_LHU     = 6'b100101;
  localparam logic [5:0] EXE_SB      = 6'b101000;
  localparam logic [5:0] EXE_SH      = 6'b101001;
  localparam logic [5:0] EXE_SW      = 6'b101011;

  // SPECIAL funct codes
  localparam logic [5:0] EXE_JR      = 6'b001000;
  localparam logic [5:0] EXE_JALR    = 6'b001001;
  localparam logic [5:0] EXE_SYSCALL = 6'b001100;
  localparam logic [5:0] EXE_BREAK   = 6'b001101;
  localparam logic [5:0] EXE_MFHI    = 6'b010000;
  localparam logic [5:0] EXE_MTHI    = 6'b010001;
  localparam logic [5:0] EXE_MFLO    = 6'b010010;
  localparam logic [5:0] EXE_MTLO    = 6'b010011;
  localparam logic [5:0] EXE_MULT    = 6'b011000;
  localparam logic [5:0] EXE_MULTU   = 6'b011001;
  localparam logic [5:0] EXE_DIV     = 6'b011010;
  localparam logic [5:0] EXE_DIVU    = 6'b011011;

  // REGIMM rt codes
  localparam logic [4:0] EXE_BLTZ    = 5'b00000;
  localparam logic [4:0] EXE_BGEZ    = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL  = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL  = 5'b10001;

  // COP0 rs codes and the full eret word
  localparam logic [4:0]  EXE_MFC0_RS = 5'b00000;
  localparam logic [4:0]  EXE_MTC0_RS = 5'b00100;
  localparam logic [31:0] EXE_ERET    = 32'h42000018;

  // Control-vector field positions
  localparam int C_REGWRITE = 0;
  localparam int C_REGDST   = 1;
  localparam int C_ALUSRC   = 2;
  localparam int C_BRANCH   = 3;
  localparam int C_MEMTOREG = 4;
  localparam int C_JUMP     = 5;
  localparam int C_JAL      = 6;
  localparam int C_JR       = 7;
  localparam int C_BAL      = 8;
  localparam int C_MEMEN    = 9;
  localparam int C_HILO     = 10;
  localparam int C_MEMWR    = 11;  // 4 bits: 11..14
  localparam int C_BREAK    = 15;
  localparam int C_SYSCALL  = 16;
  localparam int C_RESERVE  = 17;
  localparam int C_ERET     = 18;
  localparam int C_CP0WE    = 19;
  localparam int C_CP0SEL   = 20;

  // mult/multu start a multiply on the HI/LO unit
  function automatic logic isMulOp(input logic [31:0] w);
    return (w[31:26] == EXE_SPECIAL) &&
           ((w[5:0] == EXE_MULT) || (w[5:0] == EXE_MULTU));
  endfunction

  // div/divu start a divide on the HI/LO unit
  function automatic logic isDivOp(input logic [31:0] w);
    return (w[31:26] == EXE_SPECIAL) &&
           ((w[5:0] == EXE_DIV) || (w[5:0] == EXE_DIVU));
  endfunction

  // Any instruction that reads or writes HI/LO must wait for the unit
  function automatic logic isHiloOp(input logic [31:0] w);
    return (w[31:26] == EXE_SPECIAL) &&
           ((w[5:0] == EXE_MFHI) || (w[5:0] == EXE_MTHI) ||
            (w[5:0] == EXE_MFLO) || (w[5:0] == EXE_MTLO) ||
            isMulOp(w) || isDivOp(w));
  endfunction

endpackage

// File: rtl/maindec_pipe_comb.sv
// maindec_comb
// Purely combinational MIPS main decoder: instruction word in, control
// vector out (field layout from maindec_pipe_pkg).
// Ports:
//   instr_i  32-bit instruction word
//   ctrl_o   CTRL_W-bit control vector
// EN_CP0 = 0 turns every COP0-opcode encoding into a reserved instruction.
module maindec_comb
  import maindec_pipe_pkg::*;
#(
  parameter int EN_CP0 = 1
) (
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign rs    = instr_i[25:21];
  assign rt    = instr_i[20:16];

  always_comb begin
    ctrl_o = '0;
    case (op)
      EXE_SPECIAL: begin
        case (funct)
          EXE_JR:      ctrl_o[C_JR] = 1'b1;
          EXE_JALR: begin
            ctrl_o[C_REGWRITE] = 1'b1;
            ctrl_o[C_REGDST]   = 1'b1;
            ctrl_o[C_JR]       = 1'b1;
          end
          EXE_SYSCALL: ctrl_o[C_SYSCALL] = 1'b1;
          EXE_BREAK:   ctrl_o[C_BREAK]   = 1'b1;
          EXE_MFHI, EXE_MFLO: begin
            ctrl_o[C_REGWRITE] = 1'b1;
            ctrl_o[C_REGDST]   = 1'b1;
            ctrl_o[C_HILO]     = 1'b1;
          end
          EXE_MTHI, EXE_MTLO, EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU:
            ctrl_o[C_HILO] = 1'b1;
          default: begin
            ctrl_o[C_REGWRITE] = 1'b1;
            ctrl_o[C_REGDST]   = 1'b1;
          end
        endcase
      end
      // Unknown REGIMM rt decodes to a no-op rather than a reserved trap
      EXE_REGIMM: begin
        case (rt)
          EXE_BLTZ, EXE_BGEZ: ctrl_o[C_BRANCH] = 1'b1;
          EXE_BLTZAL, EXE_BGEZAL: begin
            ctrl_o[C_BRANCH]   = 1'b1;
            ctrl_o[C_REGWRITE] = 1'b1;
            ctrl_o[C_BAL]      = 1'b1;
          end
          default: ;
        endcase
      end
      EXE_J: ctrl_o[C_JUMP] = 1'b1;
      EXE_JAL: begin
        ctrl_o[C_REGWRITE] = 1'b1;
        ctrl_o[C_JAL]      = 1'b1;
      end
      EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ: ctrl_o[C_BRANCH] = 1'b1;
      EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU,
      EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI: begin
        ctrl_o[C_REGWRITE] = 1'b1;
        ctrl_o[C_ALUSRC]   = 1'b1;
      end
      EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU: begin
        ctrl_o[C_REGWRITE] = 1'b1;
        ctrl_o[C_ALUSRC]   = 1'b1;
        ctrl_o[C_MEMTOREG] = 1'b1;
        ctrl_o[C_MEMEN]    = 1'b1;
      end
      EXE_SB, EXE_SH, EXE_SW: begin
        ctrl_o[C_ALUSRC] = 1'b1;
        ctrl_o[C_MEMEN]  = 1'b1;
        if (op == EXE_SB)      ctrl_o[C_MEMWR +: 4] = 4'b0001;
        else if (op == EXE_SH) ctrl_o[C_MEMWR +: 4] = 4'b0011;
        else                   ctrl_o[C_MEMWR +: 4] = 4'b1111;
      end
      // mtc0/mfc0 require the unused [10:3] field to be zero
      EXE_COP0: begin
        if (EN_CP0 == 0) begin
          ctrl_o[C_RESERVE] = 1'b1;
        end else if (instr_i == EXE_ERET) begin
          ctrl_o[C_ERET] = 1'b1;
        end else if ((rs == EXE_MTC0_RS) && (instr_i[10:3] == 8'd0)) begin
          ctrl_o[C_CP0WE] = 1'b1;
        end else if ((rs == EXE_MFC0_RS) && (instr_i[10:3] == 8'd0)) begin
          ctrl_o[C_REGWRITE] = 1'b1;
          ctrl_o[C_CP0SEL]   = 1'b1;
        end else begin
          ctrl_o[C_RESERVE] = 1'b1;
        end
      end
      default: ctrl_o[C_RESERVE] = 1'b1;
    endcase
  end

endmodule

// File: rtl/maindec_pipe.sv
// maindec_pipe
// Registered main decoder with a valid/ready output stage and a HI/LO
// busy scoreboard.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake; instr is the incoming word
//   flush                 squashes the held and the incoming instruction
//   out_valid / out_ready downstream handshake
//   out_instr             instruction word belonging to the held controls
//   regwrite..hilo        datapath controls, memwrite byte enables
//   break_o..eret_o       exception flags; cp0we / cp0sel CP0 access
//   hilo_busy             a mult/div is still occupying HI/LO
module maindec_pipe
  import maindec_pipe_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int EN_CP0  = 1,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        regwrite,
  output logic        regdst,
  output logic        alusrc,
  output logic        branch,
  output logic        memtoreg,
  output logic        jump,
  output logic        jal,
  output logic        jr,
  output logic        bal,
  output logic        memen,
  output logic        hilo,
  output logic [3:0]  memwrite,
  output logic        break_o,
  output logic        syscall_o,
  output logic        reserve_o,
  output logic        eret_o,
  output logic        cp0we,
  output logic        cp0sel,
  output logic        hilo_busy
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              hz;
  logic              accept;

  maindec_comb #(
    .EN_CP0 (EN_CP0)
  ) u_dec (
    .instr_i (instr),
    .ctrl_o  (dec_ctrl)
  );

  // Hazard looks at the presented word regardless of in_valid, so in_ready
  // already reflects the stall before upstream commits.
  assign hz       = isHiloOp(instr) && (cnt_q != '0);
  assign in_ready = !flush && !hz && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // A new mult/div restarts the busy window; otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && isMulOp(instr)) begin
      cnt_d = MUL_CNT;
    end else if (accept && isDivOp(instr)) begin
      cnt_d = DIV_CNT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Flush only drops out_valid; the counter keeps running because the
  // mult/div it tracks has already left this stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        ctrl_q  <= dec_ctrl;
        instr_q <= instr;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign hilo_busy = (cnt_q != '0);
  assign regwrite  = ctrl_q[C_REGWRITE];
  assign regdst    = ctrl_q[C_REGDST];
  assign alusrc    = ctrl_q[C_ALUSRC];
  assign branch    = ctrl_q[C_BRANCH];
  assign memtoreg  = ctrl_q[C_MEMTOREG];
  assign jump      = ctrl_q[C_JUMP];
  assign jal       = ctrl_q[C_JAL];
  assign jr        = ctrl_q[C_JR];
  assign bal       = ctrl_q[C_BAL];
  assign memen     = ctrl_q[C_MEMEN];
  assign hilo      = ctrl_q[C_HILO];
  assign memwrite  = ctrl_q[C_MEMWR +: 4];
  assign break_o   = ctrl_q[C_BREAK];
  assign syscall_o = ctrl_q[C_SYSCALL];
  assign reserve_o = ctrl_q[C_RESERVE];
  assign eret_o    = ctrl_q[C_ERET];
  assign cp0we     = ctrl_q[C_CP0WE];
  assign cp0sel    = ctrl_q[C_CP0SEL];

endmodule

// File: tb/tb_maindec_pipe.sv
// tb_maindec_pipe
// Two instances share one stimulus stream: dutA decodes CP0, dutB does not.
// A reference decoder built from instruction mnemonics predicts each
// accepted word; a monitor pops predictions as outputs are consumed.
module tb_maindec_pipe;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  typedef struct packed {
    logic       regwrite, regdst, alusrc, branch, memtoreg, jump, jal, jr, bal, memen, hilo;
    logic [3:0] memwrite;
    logic       brk, sys, rsv, eret, cp0we, cp0sel;
  } ctrl_t;

  typedef struct {
    logic [31:0] instr;
    ctrl_t       c1;
    ctrl_t       c0;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;

  logic in_readyA, out_validA, regwriteA, regdstA, alusrcA, branchA, memtoregA, jumpA, jalA, jrA, balA, memenA, hiloA;
  logic breakA, syscallA, reserveA, eretA, cp0weA, cp0selA, busyA;
  logic [3:0] memwriteA;
  logic [31:0] out_instrA;
  logic in_readyB, out_validB, regwriteB, regdstB, alusrcB, branchB, memtoregB, jumpB, jalB, jrB, balB, memenB, hiloB;
  logic breakB, syscallB, reserveB, eretB, cp0weB, cp0selB, busyB;
  logic [3:0] memwriteB;
  logic [31:0] out_instrB;
  ctrl_t actA, actB;

  always #5 clk = ~clk;

  maindec_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .EN_CP0(1), .CNT_W(8)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_readyA), .instr(instr), .flush(flush),
    .out_valid(out_validA), .out_ready(out_ready), .out_instr(out_instrA),
    .regwrite(regwriteA), .regdst(regdstA), .alusrc(alusrcA), .branch(branchA), .memtoreg(memtoregA),
    .jump(jumpA), .jal(jalA), .jr(jrA), .bal(balA), .memen(memenA), .hilo(hiloA), .memwrite(memwriteA),
    .break_o(breakA), .syscall_o(syscallA), .reserve_o(reserveA), .eret_o(eretA),
    .cp0we(cp0weA), .cp0sel(cp0selA), .hilo_busy(busyA));

  maindec_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .EN_CP0(0), .CNT_W(8)) dutB (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_readyB), .instr(instr), .flush(flush),
    .out_valid(out_validB), .out_ready(out_ready), .out_instr(out_instrB),
    .regwrite(regwriteB), .regdst(regdstB), .alusrc(alusrcB), .branch(branchB), .memtoreg(memtoregB),
    .jump(jumpB), .jal(jalB), .jr(jrB), .bal(balB), .memen(memenB), .hilo(hiloB), .memwrite(memwriteB),
    .break_o(breakB), .syscall_o(syscallB), .reserve_o(reserveB), .eret_o(eretB),
    .cp0we(cp0weB), .cp0sel(cp0selB), .hilo_busy(busyB));

  assign actA = {regwriteA, regdstA, alusrcA, branchA, memtoregA, jumpA, jalA, jrA, balA, memenA, hiloA,
                 memwriteA, breakA, syscallA, reserveA, eretA, cp0weA, cp0selA};
  assign actB = {regwriteB, regdstB, alusrcB, branchB, memtoregB, jumpB, jalB, jrB, balB, memenB, hiloB,
                 memwriteB, breakB, syscallB, reserveB, eretB, cp0weB, cp0selB};

  int total = 0;
  int bad = 0;
  item_t sbq[$];

  // Reference-model state
  int    cntM = 0;
  bit    validM = 0;
  bit    pendM = 0;
  bit    lastRst = 0;
  bit    rdyM = 0;
  bit    busyM = 0;
  bit    monOn = 0;
  item_t pendItem;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Name the instruction the way the ISA manual would
  function automatic string mnemonic(input logic [31:0] w, input bit cp0);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    logic [4:0] rt = w[20:16];
    logic [4:0] rs = w[25:21];
    logic [7:0] mid = w[10:3];
    if (op == 6'h00) begin
      if (fn == 6'h08) return "jr";
      if (fn == 6'h09) return "jalr";
      if (fn == 6'h0c) return "syscall";
      if (fn == 6'h0d) return "break";
      if (fn == 6'h10 || fn == 6'h12) return "mfhilo";
      if (fn == 6'h11 || fn == 6'h13 || (fn >= 6'h18 && fn <= 6'h1b)) return "hiloop";
      return "alur";
    end
    if (op == 6'h01) begin
      if (rt == 5'd0 || rt == 5'd1) return "bcmpz";
      if (rt == 5'd16 || rt == 5'd17) return "bal";
      return "nop";
    end
    if (op == 6'h02) return "j";
    if (op == 6'h03) return "jal";
    if (op >= 6'h04 && op <= 6'h07) return "branch";
    if (op >= 6'h08 && op <= 6'h0f) return "alui";
    if (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25) return "load";
    if (op == 6'h28) return "sb";
    if (op == 6'h29) return "sh";
    if (op == 6'h2b) return "sw";
    if (op == 6'h10 && cp0) begin
      if (w == 32'h42000018) return "eret";
      if (rs == 5'd4 && mid == 8'd0) return "mtc0";
      if (rs == 5'd0 && mid == 8'd0) return "mfc0";
    end
    return "reserved";
  endfunction

  function automatic ctrl_t refCtrl(input logic [31:0] w, input bit cp0);
    ctrl_t c = '0;
    case (mnemonic(w, cp0))
      "jr":      c.jr = 1;
      "jalr":    begin c.regwrite = 1; c.regdst = 1; c.jr = 1; end
      "syscall": c.sys = 1;
      "break":   c.brk = 1;
      "mfhilo":  begin c.regwrite = 1; c.regdst = 1; c.hilo = 1; end
      "hiloop":  c.hilo = 1;
      "alur":    begin c.regwrite = 1; c.regdst = 1; end
      "bcmpz":   c.branch = 1;
      "bal":     begin c.branch = 1; c.regwrite = 1; c.bal = 1; end
      "nop":     ;
      "j":       c.jump = 1;
      "jal":     begin c.regwrite = 1; c.jal = 1; end
      "branch":  c.branch = 1;
      "alui":    begin c.regwrite = 1; c.alusrc = 1; end
      "load":    begin c.regwrite = 1; c.alusrc = 1; c.memtoreg = 1; c.memen = 1; end
      "sb":      begin c.alusrc = 1; c.memen = 1; c.memwrite = 4'b0001; end
      "sh":      begin c.alusrc = 1; c.memen = 1; c.memwrite = 4'b0011; end
      "sw":      begin c.alusrc = 1; c.memen = 1; c.memwrite = 4'b1111; end
      "eret":    c.eret = 1;
      "mtc0":    c.cp0we = 1;
      "mfc0":    begin c.regwrite = 1; c.cp0sel = 1; end
      default:   c.rsv = 1;
    endcase
    return c;
  endfunction

  function automatic bit usesHilo(input logic [31:0] w);
    return mnemonic(w, 1'b0) == "mfhilo" || mnemonic(w, 1'b0) == "hiloop";
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h0040};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 7))
      0: w[31:26] = 6'h00;
      1: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 7))
          0: w[5:0] = 6'h10;
          1: w[5:0] = 6'h11;
          2: w[5:0] = 6'h12;
          3: w[5:0] = 6'h13;
          4: w[5:0] = 6'h18;
          5: w[5:0] = 6'h19;
          6: w[5:0] = 6'h1a;
          default: w[5:0] = 6'h1b;
        endcase
      end
      2: begin
        w[31:26] = 6'h01;
        case ($urandom_range(0, 4))
          0: w[20:16] = 5'd0;
          1: w[20:16] = 5'd1;
          2: w[20:16] = 5'd16;
          3: w[20:16] = 5'd17;
          default: ;
        endcase
      end
      3: begin
        w[31:26] = 6'h10;
        case ($urandom_range(0, 3))
          0: w = 32'h42000018;
          1: begin w[25:21] = 5'd4; if ($urandom_range(0, 1) == 1) w[10:3] = 8'd0; end
          2: begin w[25:21] = 5'd0; if ($urandom_range(0, 1) == 1) w[10:3] = 8'd0; end
          default: ;
        endcase
      end
      4: begin
        case ($urandom_range(0, 7))
          0: w[31:26] = 6'h20;
          1: w[31:26] = 6'h21;
          2: w[31:26] = 6'h23;
          3: w[31:26] = 6'h24;
          4: w[31:26] = 6'h25;
          5: w[31:26] = 6'h28;
          6: w[31:26] = 6'h29;
          default: w[31:26] = 6'h2b;
        endcase
      end
      5: w[31:26] = 6'($urandom_range(2, 7));
      6: w[31:26] = 6'($urandom_range(8, 15));
      default: ;
    endcase
    return w;
  endfunction

  // One clock of stimulus; the model decides acceptance from the rules
  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] w, input bit ordy, input bit fl);
    bit acc;
    @(posedge clk);
    #1;
    if (lastRst) sbq.delete();
    else if (pendM) sbq.push_back(pendItem);
    rst = r; in_valid = v; instr = w; out_ready = ordy; flush = fl;
    busyM = (cntM != 0);
    rdyM = !fl && !(usesHilo(w) && busyM) && (!validM || ordy);
    acc = v && rdyM;
    lastRst = r;
    pendM = 0;
    if (r) begin
      validM = 0;
      cntM = 0;
    end else begin
      if (acc) begin
        pendM = 1;
        pendItem.instr = w;
        pendItem.c1 = refCtrl(w, 1'b1);
        pendItem.c0 = refCtrl(w, 1'b0);
      end
      if (fl) validM = 0;
      else if (acc) validM = 1;
      else if (ordy) validM = 0;
      if (acc && (w[31:26] == 6'h00) && (w[5:0] == 6'h18 || w[5:0] == 6'h19)) cntM = MUL_LAT;
      else if (acc && (w[31:26] == 6'h00) && (w[5:0] == 6'h1a || w[5:0] == 6'h1b)) cntM = DIV_LAT;
      else if (cntM > 0) cntM--;
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300 && (cntM != 0 || validM); i++) applyStimulus(0, 0, 32'h0, 1, 0);
  endtask

  // Monitor: handshake signals every cycle, payload when consumed or flushed
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (monOn) begin
        checkOutput("in_ready_A", 32'(in_readyA), 32'(rdyM));
        checkOutput("in_ready_B", 32'(in_readyB), 32'(rdyM));
        checkOutput("hilo_busy_A", 32'(busyA), 32'(busyM));
        checkOutput("hilo_busy_B", 32'(busyB), 32'(busyM));
        checkOutput("out_valid_A", 32'(out_validA), 32'(sbq.size() != 0));
        checkOutput("out_valid_B", 32'(out_validB), 32'(sbq.size() != 0));
        if (out_validA && (out_ready || flush) && sbq.size() != 0) begin
          it = sbq.pop_front();
          checkOutput("out_instr_A", out_instrA, it.instr);
          checkOutput("out_instr_B", out_instrB, it.instr);
          checkOutput("ctrl_cp0on", 32'(actA), 32'(it.c1));
          checkOutput("ctrl_cp0off", 32'(actB), 32'(it.c0));
        end
      end
    end
  end

  initial begin
    ctrl_t e;
    int stalls;

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_validA), 32'h0);
    checkOutput("rst_out_instr", out_instrA, 32'h0);
    checkOutput("rst_ctrl_A", 32'(actA), 32'h0);
    checkOutput("rst_ctrl_B", 32'(actB), 32'h0);
    checkOutput("rst_busy", 32'(busyA), 32'h0);
    monOn = 1;

    // lw
    applyStimulus(0, 1, itype(6'h23), 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    e = '0; e.regwrite = 1; e.alusrc = 1; e.memtoreg = 1; e.memen = 1;
    checkOutput("lw_valid", 32'(out_validA), 32'h1);
    checkOutput("lw_ctrl", 32'(actA), 32'(e));

    // sw, sh, sb back-to-back
    applyStimulus(0, 1, itype(6'h2b), 1, 0);
    applyStimulus(0, 1, itype(6'h29), 1, 0);
    @(negedge clk);
    checkOutput("sw_memwrite", 32'(memwriteA), 32'hf);
    checkOutput("sh_in_ready", 32'(in_readyA), 32'h1);
    applyStimulus(0, 1, itype(6'h28), 1, 0);
    @(negedge clk);
    checkOutput("sh_memwrite", 32'(memwriteA), 32'h3);
    checkOutput("sb_in_ready", 32'(in_readyA), 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("sb_memwrite", 32'(memwriteA), 32'h1);

    // div then mflo
    waitIdle();
    applyStimulus(0, 1, rtype(6'h1a), 1, 0);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, rtype(6'h12), 1, 0);
      @(negedge clk);
      if (in_readyA) break;
      stalls++;
    end
    checkOutput("div_stall_cycles", 32'(stalls), 32'(DIV_LAT));
    checkOutput("div_busy_at_accept", 32'(busyA), 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);

    // divu flags, then multu followed by mfhi
    waitIdle();
    applyStimulus(0, 1, rtype(6'h1b), 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("divu_hilo", 32'(hiloA), 32'h1);
    checkOutput("divu_reserve", 32'(reserveA), 32'h0);
    waitIdle();
    applyStimulus(0, 1, rtype(6'h19), 1, 0);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, rtype(6'h10), 1, 0);
      @(negedge clk);
      if (in_readyA) break;
      stalls++;
    end
    checkOutput("mul_stall_cycles", 32'(stalls), 32'(MUL_LAT));
    applyStimulus(0, 0, 32'h0, 1, 0);

    // held add squashed by flush; incoming word refused
    waitIdle();
    applyStimulus(0, 1, rtype(6'h20), 0, 0);
    applyStimulus(0, 1, itype(6'h23), 0, 1);
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_readyA), 32'h0);
    checkOutput("flush_held_valid", 32'(out_validA), 32'h1);
    applyStimulus(0, 0, 32'h0, 0, 0);
    @(negedge clk);
    checkOutput("flush_out_valid", 32'(out_validA), 32'h0);

    // eret with and without CP0, then an unknown opcode
    applyStimulus(0, 1, 32'h42000018, 1, 0);
    applyStimulus(0, 1, 32'hfc000000, 1, 0);
    @(negedge clk);
    checkOutput("eret_on", 32'(eretA), 32'h1);
    checkOutput("eret_off_reserve", 32'(reserveB), 32'h1);
    checkOutput("eret_off_eret", 32'(eretB), 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("op3f_reserve_A", 32'(reserveA), 32'h1);
    checkOutput("op3f_reserve_B", 32'(reserveB), 32'h1);

    // reset while HI/LO is busy and an output is held
    waitIdle();
    applyStimulus(0, 1, rtype(6'h1a), 0, 0);
    applyStimulus(1, 1, rtype(6'h12), 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    @(negedge clk);
    checkOutput("rst_busy_cleared", 32'(busyA), 32'h0);
    checkOutput("rst_valid_cleared", 32'(out_validA), 32'h0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), randInstr(),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    applyStimulus(0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
